// File: rtl/chacha_pkg.sv
// Shared ChaCha20 scheduler types: word type, sigma constants, quarter-round
// index table and the scheduler state encoding.
package chacha_pkg;

  typedef logic [31:0] word_t;

  // "expand 32-byte k", word 0 in the low slot
  localparam word_t [3:0] SIGMA = {32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};

  // QR_IDX[slot][j]: matrix index of operand j (a=0..d=3); slots 0-3 columns, 4-7 diagonals
  localparam logic [7:0][3:0][3:0] QR_IDX = {
    {4'd14, 4'd9,  4'd4, 4'd3},
    {4'd13, 4'd8,  4'd7, 4'd2},
    {4'd12, 4'd11, 4'd6, 4'd1},
    {4'd15, 4'd10, 4'd5, 4'd0},
    {4'd15, 4'd11, 4'd7, 4'd3},
    {4'd14, 4'd10, 4'd6, 4'd2},
    {4'd13, 4'd9,  4'd5, 4'd1},
    {4'd12, 4'd8,  4'd4, 4'd0}
  };

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_FEED,
    S_OUT
  } sched_state_t;

endpackage

// File: rtl/chacha_qr_sel.sv
// Picks the four quarter-round operands for a slot out of the 16-word working matrix.
module chacha_qr_sel
  import chacha_pkg::*;
(
  input  word_t [15:0] work_i,
  input  logic  [2:0]  slot_i,
  output word_t [3:0]  op_o
);

  always_comb begin
    for (int j = 0; j < 4; j++) begin
      op_o[j] = work_i[QR_IDX[slot_i][j]];
    end
  end

endmodule

// File: rtl/chacha_round_scheduler.sv
// Drives one external quarter-round core through full ChaCha20 block computations,
// one keystream block per counter value, with feed-forward and a valid/ready output.
module chacha_round_scheduler
  import chacha_pkg::*;
#(
  parameter int DOUBLE_ROUNDS = 10,
  parameter int BLK_CNT_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  word_t [7:0]          key_i,
  input  word_t [2:0]          nonce_i,
  input  logic  [31:0]         counter_init_i,
  input  logic  [BLK_CNT_W-1:0] num_blocks_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 qr_start_o,
  output word_t                qr_a_o,
  output word_t                qr_b_o,
  output word_t                qr_c_o,
  output word_t                qr_d_o,
  input  logic                 qr_done_i,
  input  word_t                qr_a_i,
  input  word_t                qr_b_i,
  input  word_t                qr_c_i,
  input  word_t                qr_d_i,
  output logic                 ks_valid_o,
  input  logic                 ks_ready_i,
  output word_t [15:0]         ks_block_o,
  output logic  [BLK_CNT_W-1:0] blocks_produced_o
);

  localparam int DR_W = (DOUBLE_ROUNDS > 1) ? $clog2(DOUBLE_ROUNDS) : 1;

  sched_state_t         state_q, state_d;
  word_t [7:0]          key_q, key_d;
  word_t [2:0]          nonce_q, nonce_d;
  logic  [31:0]         ctr_q, ctr_d;
  logic  [BLK_CNT_W-1:0] num_q, num_d;
  logic  [BLK_CNT_W-1:0] bp_q, bp_d;
  word_t [15:0]         init_q, init_d;
  word_t [15:0]         work_q, work_d;
  logic  [2:0]          slot_q, slot_d;
  logic  [DR_W-1:0]     dround_q, dround_d;
  word_t [3:0]          op_q, op_d;
  logic                 qr_start_q, qr_start_d;
  word_t [15:0]         ks_q, ks_d;
  logic                 ks_valid_q, ks_valid_d;
  logic                 done_q, done_d;

  word_t [3:0]          sel_op;
  word_t [3:0]          qr_res;
  word_t [15:0]         init_mat;

  chacha_qr_sel u_sel (
    .work_i (work_q),
    .slot_i (slot_q),
    .op_o   (sel_op)
  );

  assign qr_res   = {qr_d_i, qr_c_i, qr_b_i, qr_a_i};
  // row-major: sigma, key k0..k7, counter, nonce n0..n2
  assign init_mat = {nonce_q, ctr_q, key_q, SIGMA};

  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    nonce_d    = nonce_q;
    ctr_d      = ctr_q;
    num_d      = num_q;
    bp_d       = bp_q;
    init_d     = init_q;
    work_d     = work_q;
    slot_d     = slot_q;
    dround_d   = dround_q;
    op_d       = op_q;
    qr_start_d = 1'b0;
    ks_d       = ks_q;
    ks_valid_d = ks_valid_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (num_blocks_i != '0) begin
            key_d   = key_i;
            nonce_d = nonce_i;
            ctr_d   = counter_init_i;
            num_d   = num_blocks_i;
            bp_d    = '0;
            state_d = S_LOAD;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        init_d   = init_mat;
        work_d   = init_mat;
        slot_d   = '0;
        dround_d = '0;
        state_d  = S_ISSUE;
      end
      S_ISSUE: begin
        qr_start_d = 1'b1;
        op_d       = sel_op;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (qr_done_i) begin
          for (int j = 0; j < 4; j++) begin
            work_d[QR_IDX[slot_q][j]] = qr_res[j];
          end
          if (slot_q == 3'd7 && dround_q == DR_W'(DOUBLE_ROUNDS - 1)) begin
            state_d = S_FEED;
          end else begin
            slot_d  = slot_q + 3'd1;
            if (slot_q == 3'd7) dround_d = dround_q + 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      S_FEED: begin
        for (int i = 0; i < 16; i++) begin
          ks_d[i] = work_q[i] + init_q[i];
        end
        ks_valid_d = 1'b1;
        state_d    = S_OUT;
      end
      S_OUT: begin
        if (ks_ready_i) begin
          ks_valid_d = 1'b0;
          bp_d       = bp_q + 1'b1;
          ctr_d      = ctr_q + 32'd1;
          if (bp_q == num_q - BLK_CNT_W'(1)) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      key_q      <= '0;
      nonce_q    <= '0;
      ctr_q      <= '0;
      num_q      <= '0;
      bp_q       <= '0;
      init_q     <= '0;
      work_q     <= '0;
      slot_q     <= '0;
      dround_q   <= '0;
      op_q       <= '0;
      qr_start_q <= 1'b0;
      ks_q       <= '0;
      ks_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      nonce_q    <= nonce_d;
      ctr_q      <= ctr_d;
      num_q      <= num_d;
      bp_q       <= bp_d;
      init_q     <= init_d;
      work_q     <= work_d;
      slot_q     <= slot_d;
      dround_q   <= dround_d;
      op_q       <= op_d;
      qr_start_q <= qr_start_d;
      ks_q       <= ks_d;
      ks_valid_q <= ks_valid_d;
      done_q     <= done_d;
    end
  end

  assign busy_o            = (state_q != S_IDLE);
  assign done_o            = done_q;
  assign qr_start_o        = qr_start_q;
  assign qr_a_o            = op_q[0];
  assign qr_b_o            = op_q[1];
  assign qr_c_o            = op_q[2];
  assign qr_d_o            = op_q[3];
  assign ks_valid_o        = ks_valid_q;
  assign ks_block_o        = ks_q;
  assign blocks_produced_o = bp_q;

endmodule

// File: tb/tb_chacha_round_scheduler.sv
// Bench for chacha_round_scheduler: behavioural quarter-round core with programmable
// latency, a reference ChaCha20 block model and directed jobs.
module tb_chacha_round_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              start_i = 1'b0;
  logic [7:0][31:0]  key_i = '0;
  logic [2:0][31:0]  nonce_i = '0;
  logic [31:0]       ctr_i = '0;
  logic [3:0]        nb_i = '0;
  logic              busy_o, done_o, qr_start_o, ks_valid_o;
  logic [31:0]       qr_a_o, qr_b_o, qr_c_o, qr_d_o;
  logic              qr_done_i = 1'b0;
  logic [31:0]       qr_a_i = '0, qr_b_i = '0, qr_c_i = '0, qr_d_i = '0;
  logic              ks_ready_i = 1'b1;
  logic [15:0][31:0] ks_block_o;
  logic [3:0]        bp_o;

  chacha_round_scheduler dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .key_i(key_i), .nonce_i(nonce_i),
    .counter_init_i(ctr_i), .num_blocks_i(nb_i), .busy_o(busy_o), .done_o(done_o),
    .qr_start_o(qr_start_o), .qr_a_o(qr_a_o), .qr_b_o(qr_b_o), .qr_c_o(qr_c_o), .qr_d_o(qr_d_o),
    .qr_done_i(qr_done_i), .qr_a_i(qr_a_i), .qr_b_i(qr_b_i), .qr_c_i(qr_c_i), .qr_d_i(qr_d_i),
    .ks_valid_o(ks_valid_o), .ks_ready_i(ks_ready_i), .ks_block_o(ks_block_o),
    .blocks_produced_o(bp_o)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [3:0][31:0] qr(input logic [31:0] a, b, c, d);
    a += b; d ^= a; d = rotl(d, 16);
    c += d; b ^= c; b = rotl(b, 12);
    a += b; d ^= a; d = rotl(d, 8);
    c += d; b ^= c; b = rotl(b, 7);
    return {d, c, b, a};
  endfunction

  function automatic logic [15:0][31:0] qrs(input logic [15:0][31:0] s, input int a, b, c, d);
    logic [3:0][31:0] r;
    r = qr(s[a], s[b], s[c], s[d]);
    s[a] = r[0]; s[b] = r[1]; s[c] = r[2]; s[d] = r[3];
    return s;
  endfunction

  function automatic logic [15:0][31:0] chacha_blk(input logic [7:0][31:0] k,
                                                   input logic [2:0][31:0] n,
                                                   input logic [31:0] c);
    logic [15:0][31:0] s, x;
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) s[4+i] = k[i];
    s[12] = c;
    for (int i = 0; i < 3; i++) s[13+i] = n[i];
    x = s;
    for (int r = 0; r < 10; r++) begin
      x = qrs(x, 0, 4, 8, 12); x = qrs(x, 1, 5, 9, 13);
      x = qrs(x, 2, 6, 10, 14); x = qrs(x, 3, 7, 11, 15);
      x = qrs(x, 0, 5, 10, 15); x = qrs(x, 1, 6, 11, 12);
      x = qrs(x, 2, 7, 8, 13); x = qrs(x, 3, 4, 9, 14);
    end
    for (int i = 0; i < 16; i++) x[i] = x[i] + s[i];
    return x;
  endfunction

  // ---------------- quarter-round core with programmable latency ----------------
  int               core_lat = 0;
  int               qs_cnt = 0;
  logic [15:0][31:0] ctr_seen = '0;
  logic             pend = 1'b0;
  int               pcnt = 0;
  logic [3:0][31:0] pres = '0;

  always @(posedge clk) begin
    #1;
    qr_done_i = 1'b0;
    if (!rst_n) begin
      pend = 1'b0;
    end else if (pend) begin
      if (pcnt == 0) begin
        qr_done_i = 1'b1;
        {qr_d_i, qr_c_i, qr_b_i, qr_a_i} = pres;
        pend = 1'b0;
      end else begin
        pcnt--;
      end
    end
    if (!busy_o) qs_cnt = 0;
    if (rst_n && qr_start_o) begin
      if (qs_cnt % 80 == 0 && qs_cnt / 80 < 16) ctr_seen[qs_cnt/80] = qr_d_o;
      qs_cnt++;
      pres = qr(qr_a_o, qr_b_o, qr_c_o, qr_d_o);
      pend = 1'b1;
      pcnt = core_lat;
    end
  end

  // ---------------- compare process ----------------
  logic [15:0][15:0][31:0] exp_blk;
  logic [15:0][31:0]       last_blk = '0;
  logic [3:0][31:0]        op_cap = '0;
  int hs_idx = 0;
  int done_cnt = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (qr_start_o) op_cap = {qr_d_o, qr_c_o, qr_b_o, qr_a_o};
      if (qr_done_i && busy_o && !qr_start_o)
        chk("qr_operands_held", {qr_d_o, qr_c_o, qr_b_o, qr_a_o}, op_cap);
      if (ks_valid_o && ks_ready_i) begin
        chk("ks_block", ks_block_o, exp_blk[hs_idx]);
        chk("blocks_produced_at_hs", bp_o, hs_idx);
        last_blk = ks_block_o;
        hs_idx++;
      end
      if (!busy_o) hs_idx = 0;
      if (done_o) done_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic run_job(input logic [7:0][31:0] k, input logic [2:0][31:0] n,
                         input logic [31:0] c, input int nb, input int lat,
                         input bit hold_first, input bit busy_start);
    int d0;
    bit got;
    logic [15:0][31:0] cap;
    core_lat = lat;
    for (int b = 0; b < nb; b++) exp_blk[b] = chacha_blk(k, n, c + 32'(b));
    d0 = done_cnt;
    @(posedge clk); #1;
    key_i = k; nonce_i = n; ctr_i = c; nb_i = 4'(nb); start_i = 1'b1;
    if (hold_first) ks_ready_i = 1'b0;
    @(posedge clk); #1;
    start_i = 1'b0;
    if (busy_start) begin
      repeat (40) @(posedge clk);
      #1; start_i = 1'b1; nb_i = 4'd5; key_i = ~k;
      @(posedge clk); #1; start_i = 1'b0;
    end
    if (hold_first) begin
      got = 1'b0;
      for (int i = 0; i < 30000 && !got; i++) begin
        @(negedge clk);
        got = ks_valid_o;
      end
      chk("ks_valid_wait", got, 1'b1);
      cap = ks_block_o;
      chk("ks_first_vs_model", cap, exp_blk[0]);
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        chk("ks_valid_held", ks_valid_o, 1'b1);
        chk("ks_block_held", ks_block_o, cap);
        chk("bp_held", bp_o, 4'd0);
      end
      @(posedge clk); #1; ks_ready_i = 1'b1;
    end
    got = 1'b0;
    for (int i = 0; i < 30000 && !got; i++) begin
      @(negedge clk);
      got = (done_cnt != d0);
    end
    chk("done_wait", got, 1'b1);
    repeat (4) @(negedge clk);
    chk("done_pulses", done_cnt - d0, 1);
    chk("idle_after_job", busy_o, 1'b0);
    chk("blocks_produced_final", bp_o, 4'(nb));
  endtask

  logic [7:0][31:0]  rfc_key;
  logic [2:0][31:0]  rfc_nonce;
  logic [15:0][31:0] blk_fast;
  logic [3:0][31:0]  qv;

  initial begin
    for (int i = 0; i < 8; i++)
      rfc_key[i] = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
    rfc_nonce = {32'h00000000, 32'h4a000000, 32'h09000000};

    // model pinned against published vectors
    qv = qr(32'h11111111, 32'h01020304, 32'h9b8d6f43, 32'h01234567);
    chk("model_qr", qv, {32'h5881c4bb, 32'h4581472e, 32'hcb1cf8ce, 32'hea2a92f4});
    blk_fast = chacha_blk(rfc_key, rfc_nonce, 32'd1);
    chk("model_blk_w0", blk_fast[0], 32'he4e7f110);
    chk("model_blk_w15", blk_fast[15], 32'h4e3c50a2);

    #2;
    chk("reset_ctl", {busy_o, done_o, qr_start_o, ks_valid_o}, 4'b0);
    chk("reset_data", {ks_block_o, qr_a_o, qr_b_o, qr_c_o, qr_d_o, bp_o}, '0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // zero-block request: done next cycle, never busy
    @(posedge clk); #1; nb_i = 4'd0; start_i = 1'b1;
    @(posedge clk); #1; start_i = 1'b0;
    @(negedge clk);
    chk("zero_blk_done", done_o, 1'b1);
    chk("zero_blk_busy", busy_o, 1'b0);
    @(negedge clk);
    chk("zero_blk_done_clear", done_o, 1'b0);

    // RFC block, single-cycle core
    run_job(rfc_key, rfc_nonce, 32'd1, 1, 1, 1'b0, 1'b0);
    chk("rfc_dut_w0", last_blk[0], 32'he4e7f110);
    chk("rfc_dut_w15", last_blk[15], 32'h4e3c50a2);

    // counter wrap across three blocks
    run_job(rfc_key, rfc_nonce, 32'hFFFFFFFF, 3, 0, 1'b0, 1'b0);
    chk("ctr_blk0", ctr_seen[0], 32'hFFFFFFFF);
    chk("ctr_blk1", ctr_seen[1], 32'h00000000);
    chk("ctr_blk2", ctr_seen[2], 32'h00000001);

    // back-pressure on first block of two
    run_job(~rfc_key, rfc_nonce, 32'h12345678, 2, 2, 1'b1, 1'b0);
    chk("bp_ctr_blk1", ctr_seen[1], 32'h12345679);

    // latency independence, start while busy ignored
    run_job(rfc_key, rfc_nonce, 32'd7, 1, 0, 1'b0, 1'b1);
    blk_fast = last_blk;
    run_job(rfc_key, rfc_nonce, 32'd7, 1, 7, 1'b0, 1'b1);
    chk("lat0_vs_lat7", last_blk, blk_fast);

    // reset during WAIT of double round 4
    core_lat = 3;
    @(posedge clk); #1;
    key_i = rfc_key; nonce_i = rfc_nonce; ctr_i = 32'd1; nb_i = 4'd1; start_i = 1'b1;
    @(posedge clk); #1; start_i = 1'b0;
    for (int i = 0; i < 5000 && qs_cnt < 37; i++) @(negedge clk);
    chk("reach_dround4", qs_cnt, 37);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_ctl", {busy_o, done_o, qr_start_o, ks_valid_o}, 4'b0);
    chk("abort_ops", {qr_a_o, qr_b_o, qr_c_o, qr_d_o}, '0);
    chk("abort_ks", ks_block_o, '0);
    chk("abort_bp", bp_o, 4'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_no_done", done_o, 1'b0);
    run_job(rfc_key, rfc_nonce, 32'd1, 1, 2, 1'b0, 1'b0);
    chk("post_rst_w0", last_blk[0], 32'he4e7f110);
    chk("post_rst_w15", last_blk[15], 32'h4e3c50a2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
